// File: rtl/i2c_pkg.sv
// i2c_pkg: shared I2C definitions for the target and for benches that pair it with the master.
//   i2c_state_t   FSM state encoding (legacy-compatible plain vector with named constants)
//   I2C_ACK/NACK  SDA level seen during the acknowledge bit
package i2c_pkg;
    typedef logic [3:0] i2c_state_t;
    localparam i2c_state_t S_IDLE      = 4'd0;
    localparam i2c_state_t S_ADDR      = 4'd1;
    localparam i2c_state_t S_ADDR_ACK  = 4'd2;
    localparam i2c_state_t S_PTR       = 4'd3;
    localparam i2c_state_t S_PTR_ACK   = 4'd4;
    localparam i2c_state_t S_WDATA     = 4'd5;
    localparam i2c_state_t S_WDATA_ACK = 4'd6;
    localparam i2c_state_t S_RLOAD     = 4'd7;
    localparam i2c_state_t S_RDATA     = 4'd8;
    localparam i2c_state_t S_RACK      = 4'd9;
    localparam i2c_state_t S_WAIT_STOP = 4'd10;
    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;
endpackage

// File: rtl/i2c_line_cond.sv
// i2c_line_cond: synchronises SCL/SDA into clk and detects SCL edges, START and STOP.
//   clk, rst_n      clock and asynchronous active-high reset
//   scl_i, sda_i    raw pad inputs
//   sda             conditioned SDA level
//   scl_rise/fall   one-cycle SCL edge pulses
//   start/stop      one-cycle bus condition pulses (SDA edge while SCL high)
// Optional build macro I2C_SLAVE_GLITCH_FILTER_EN inserts a 3-sample agreement filter
// after the synchroniser on both lines.
module i2c_line_cond (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);
    // bit 1 = SCL, bit 0 = SDA; idle bus reads high
    logic [1:0] s1, s2, lv, pv;
    always_ff @(posedge clk or posedge rst_n)
        if (rst_n) begin
            s1 <= 2'b11;
            s2 <= 2'b11;
            pv <= 2'b11;
        end else begin
            s1 <= {scl_i, sda_i};
            s2 <= s1;
            pv <= lv;
        end
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [1:0] h0, h1, f, m;
    // a line only moves once three consecutive synced samples agree
    assign m = ~(s2 ^ h0) & ~(h0 ^ h1);
    always_ff @(posedge clk or posedge rst_n)
        if (rst_n) begin
            h0 <= 2'b11;
            h1 <= 2'b11;
            f  <= 2'b11;
        end else begin
            h0 <= s2;
            h1 <= h0;
            f  <= (f & ~m) | (s2 & m);
        end
    assign lv = f;
`else
    assign lv = s2;
`endif
    assign sda      = lv[0];
    assign scl_rise = lv[1] & ~pv[1];
    assign scl_fall = ~lv[1] & pv[1];
    assign start    = lv[1] & pv[1] & pv[0] & ~lv[0];
    assign stop     = lv[1] & pv[1] & ~pv[0] & lv[0];
endmodule

// File: rtl/i2c_slave_regs.sv
// i2c_slave_regs: I2C target mapping bus transfers onto a byte-wide register port.
//   clk, rst_n            clock and asynchronous active-high reset
//   scl_i, sda_i          asynchronous pad inputs
//   sda_oe                1 pulls SDA low (open drain)
//   reg_addr              auto-incrementing register pointer, persists across transfers
//   reg_wdata, reg_wr_en  write data with one-cycle strobe
//   reg_rd_en, reg_rdata  one-cycle read request, data returned the following cycle
//   busy                  high from address match until the transfer is left
// Optional build macro I2C_SLAVE_GLITCH_FILTER_EN (see i2c_line_cond).
module i2c_slave_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         REG_AW     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe,
    output logic [REG_AW-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_wr_en,
    output logic              reg_rd_en,
    input  logic [7:0]        reg_rdata,
    output logic              busy
);
    logic       sda, scl_rise, scl_fall, start, stop, rw;
    logic [3:0] cnt;
    logic [1:0] rl;
    logic [7:0] sh, byte_in;
    i2c_state_t state;

    i2c_line_cond u_cond (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    assign byte_in = {sh[6:0], sda};

    always_ff @(posedge clk or posedge rst_n)
        if (rst_n) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            rl        <= 2'd0;
            sh        <= 8'd0;
            rw        <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= 8'd0;
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
        end else begin
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            // pointer advances the cycle after each write strobe
            if (reg_wr_en) reg_addr <= reg_addr + REG_AW'(1);
            if (start) begin
                state  <= S_ADDR;
                cnt    <= 4'd0;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else if (stop) begin
                state  <= S_IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else case (state)
                S_ADDR: if (scl_rise) begin
                    sh  <= byte_in;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd7) begin
                        rw <= sda;
                        if (sh[6:0] == SLAVE_ADDR) begin
                            state <= S_ADDR_ACK;
                            busy  <= 1'b1;
                        end else state <= S_WAIT_STOP;
                    end
                end
                // first fall starts the ACK bit, second fall ends it
                S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: if (scl_fall) begin
                    sda_oe <= ~sda_oe;
                    cnt    <= 4'd0;
                    if (!sda_oe) reg_wr_en <= (state == S_WDATA_ACK);
                    else if (state == S_ADDR_ACK && rw) begin
                        reg_rd_en <= 1'b1;
                        rl        <= 2'd0;
                        state     <= S_RLOAD;
                    end else state <= (state == S_ADDR_ACK) ? S_PTR : S_WDATA;
                end
                S_PTR, S_WDATA: if (scl_rise) begin
                    sh  <= byte_in;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd7) begin
                        if (state == S_PTR) reg_addr <= REG_AW'(byte_in);
                        else reg_wdata <= byte_in;
                        state <= (state == S_PTR) ? S_PTR_ACK : S_WDATA_ACK;
                    end
                end
                // rl 0: request out, 1: capture data, 2: drive MSB and advance pointer
                S_RLOAD: begin
                    rl <= rl + 2'd1;
                    if (rl == 2'd1) sh <= reg_rdata;
                    if (rl == 2'd2) begin
                        sda_oe   <= ~sh[7];
                        reg_addr <= reg_addr + REG_AW'(1);
                        cnt      <= 4'd0;
                        state    <= S_RDATA;
                    end
                end
                S_RDATA: if (scl_rise) cnt <= cnt + 4'd1;
                else if (scl_fall) begin
                    if (cnt == 4'd8) begin
                        sda_oe <= 1'b0;
                        cnt    <= 4'd0;
                        state  <= S_RACK;
                    end else begin
                        sda_oe <= ~sh[6];
                        sh     <= {sh[6:0], 1'b0};
                    end
                end
                S_RACK: if (scl_rise) begin
                    if (sda == I2C_NACK) state <= S_WAIT_STOP;
                    else cnt <= 4'd1;
                end else if (scl_fall && cnt == 4'd1) begin
                    reg_rd_en <= 1'b1;
                    rl        <= 2'd0;
                    state     <= S_RLOAD;
                end
                default: ;
            endcase
        end
endmodule

// File: tb/tb_i2c_slave_regs.sv
// tb_i2c_slave_regs: directed I2C master transactions against i2c_slave_regs with a
// register-file model, strobe monitor and hand-computed expectations.
module tb_i2c_slave_regs;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       m_scl = 1'b1, m_sda = 1'b1, glitch = 1'b0;
    logic       scl_i, sda_i, sda_oe, reg_wr_en, reg_rd_en, busy;
    logic [7:0] reg_addr, reg_wdata, reg_rdata = 8'h00;
    logic [7:0] mem [256];
    logic [15:0] wq[$];
    logic [7:0]  rq[$];
    logic       oe_seen = 1'b0, both_seen = 1'b0;
    int         n_vec = 0, n_bad = 0;
    logic       a0, a1, a2;
    logic [7:0] d;

    always #5 clk = ~clk;
    assign scl_i = m_scl | glitch;
    assign sda_i = m_sda & ~sda_oe;

    i2c_slave_regs dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wr_en (reg_wr_en),
        .reg_rd_en (reg_rd_en),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    always @(negedge clk) begin
        if (reg_wr_en) wq.push_back({reg_addr, reg_wdata});
        if (reg_rd_en) begin
            rq.push_back(reg_addr);
            reg_rdata = mem[reg_addr];
        end
        if (reg_wr_en && reg_rd_en) both_seen = 1'b1;
        if (sda_oe) oe_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic q();
        repeat (10) @(negedge clk);
    endtask

    task automatic bit_io(input logic b, output logic r);
        m_sda = b;
        q();
        m_scl = 1'b1;
        q();
        r = sda_i;
        q();
        m_scl = 1'b0;
        q();
    endtask

    task automatic i2c_start();
        m_sda = 1'b1;
        q();
        m_scl = 1'b1;
        q();
        m_sda = 1'b0;
        q();
        m_scl = 1'b0;
        q();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0;
        q();
        m_scl = 1'b1;
        q();
        m_sda = 1'b1;
        q();
    endtask

    task automatic wr_byte(input logic [7:0] v, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_io(v[i], r);
        bit_io(1'b1, r);
        ack = ~r;
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] v);
        logic r;
        for (int i = 0; i < 8; i++) begin
            bit_io(1'b1, r);
            v = {v[6:0], r};
        end
        bit_io(nack, r);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5A);
        repeat (3) @(negedge clk);
        chk("rst_oe", sda_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", reg_addr, 0);
        chk("rst_wdata", reg_wdata, 0);
        chk("rst_strobes", {reg_wr_en, reg_rd_en}, 0);
        rst_n = 1'b0;
        q();

        // write 0x10 <= 0xDE
        wq.delete();
        i2c_start();
        wr_byte(8'hA0, a0);
        chk("w_busy", busy, 1);
        wr_byte(8'h10, a1);
        wr_byte(8'hDE, a2);
        i2c_stop();
        chk("w_acks", {a0, a1, a2}, 3'b111);
        chk("w_count", wq.size(), 1);
        chk("w_entry", wq.size() > 0 ? wq[0] : 16'hxxxx, 16'h10DE);
        chk("w_busy_stop", busy, 0);
        chk("w_ptr", reg_addr, 8'h11);

        // pointer 0x20, repeated start, read one byte with NACK
        mem[8'h20] = 8'hAB;
        rq.delete();
        i2c_start();
        wr_byte(8'hA0, a0);
        wr_byte(8'h20, a1);
        i2c_start();
        wr_byte(8'hA1, a2);
        chk("r_acks", {a0, a1, a2}, 3'b111);
        rd_byte(1'b1, d);
        chk("r_data", d, 8'hAB);
        chk("r_rd_count", rq.size(), 1);
        chk("r_rd_addr", rq.size() > 0 ? rq[0] : 8'hxx, 8'h20);
        chk("r_nack_rel", sda_oe, 0);
        i2c_stop();
        chk("r_busy_stop", busy, 0);

        // foreign address is ignored
        wq.delete();
        rq.delete();
        oe_seen = 1'b0;
        i2c_start();
        wr_byte(8'h78, a0);
        wr_byte(8'h55, a1);
        chk("x_acks", {a0, a1}, 2'b00);
        chk("x_busy", busy, 0);
        i2c_stop();
        chk("x_oe_seen", oe_seen, 0);
        chk("x_strobes", wq.size() + rq.size(), 0);

        // pointer wrap on consecutive writes
        wq.delete();
        i2c_start();
        wr_byte(8'hA0, a0);
        wr_byte(8'hFF, a1);
        wr_byte(8'h11, a2);
        wr_byte(8'h22, a0);
        i2c_stop();
        chk("wrap_count", wq.size(), 2);
        chk("wrap_w0", wq.size() > 0 ? wq[0] : 16'hxxxx, 16'hFF11);
        chk("wrap_w1", wq.size() > 1 ? wq[1] : 16'hxxxx, 16'h0022);

        // sequential read of three bytes from 0x05
        mem[5] = 8'h3C;
        mem[6] = 8'hC3;
        mem[7] = 8'h81;
        rq.delete();
        i2c_start();
        wr_byte(8'hA0, a0);
        wr_byte(8'h05, a1);
        i2c_start();
        wr_byte(8'hA1, a2);
        rd_byte(1'b0, d);
        chk("seq_d0", d, 8'h3C);
        rd_byte(1'b0, d);
        chk("seq_d1", d, 8'hC3);
        rd_byte(1'b1, d);
        chk("seq_d2", d, 8'h81);
        i2c_stop();
        chk("seq_rd_addrs", {rq.size() > 0 ? rq[0] : 8'hxx, rq.size() > 1 ? rq[1] : 8'hxx,
                             rq.size() > 2 ? rq[2] : 8'hxx}, 24'h050607);
        chk("seq_ptr", reg_addr, 8'h08);

        // reset while driving a read bit
        mem[0] = 8'h00;
        i2c_start();
        wr_byte(8'hA0, a0);
        wr_byte(8'h00, a1);
        i2c_start();
        wr_byte(8'hA1, a2);
        for (int i = 0; i < 200 && !sda_oe; i++) @(negedge clk);
        chk("mid_oe", sda_oe, 1);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_oe", sda_oe, 0);
        @(negedge clk);
        chk("mid_rst_addr", reg_addr, 0);
        rst_n = 1'b0;
        m_sda = 1'b1;
        q();
        m_scl = 1'b1;
        q();
        i2c_start();
        wr_byte(8'hA0, a0);
        chk("post_rst_ack", a0, 1);
        i2c_stop();

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        i2c_start();
        @(negedge clk);
        glitch = 1'b1;
        @(negedge clk);
        glitch = 1'b0;
        q();
        wr_byte(8'hA0, a0);
        chk("glitch_ack", a0, 1);
        i2c_stop();
`endif

        chk("no_rd_wr_overlap", both_seen, 0);
        chk("end_busy", busy, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
